// File: rtl/fixpoint_pkg.sv
// ---------------------------------------------------------------------------
// fixpoint_pkg
// Shared definitions for the fixed-point adder arbiter slice.
//   - Default operand/result formats and derived widths (W_OP, W_RES).
//   - Requester tag carried alongside the shared adder's latency.
//   - Small helpers for id matching and round-robin pointer wrap.
// The tag id is sized for the largest supported requester count (8), so one
// tag type serves every NREQ configuration.
// ---------------------------------------------------------------------------
package fixpoint_pkg;

    localparam int WI_DEF   = 8;
    localparam int WF_DEF   = 8;
    localparam int WIO_DEF  = 8;
    localparam int WFO_DEF  = 8;
    localparam int W_OP     = WI_DEF + WF_DEF;
    localparam int W_RES    = WIO_DEF + WFO_DEF;

    localparam int MAX_NREQ = 8;
    localparam int ID_W     = $clog2(MAX_NREQ);

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    // One bit of the one-hot decode of id: true when id selects requester i.
    function automatic logic onehot_bit(input req_id_t id, input int i);
        return int'(id) == i;
    endfunction

    // Round-robin successor of id among n requesters.
    function automatic req_id_t wrap_inc(input req_id_t id, input int n);
        return (int'(id) + 1 >= n) ? '0 : id + req_id_t'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Grants the first asserted request found
// when searching ptr, ptr+1, ... modulo NREQ.
// Ports:
//   req      in   NREQ  request vector
//   en       in   1     0 forces an empty grant
//   ptr      in   ID_W  highest-priority requester this cycle
//   grant    out  NREQ  one-hot grant (all 0 when nothing granted)
//   grant_id out  ID_W  index of the granted requester (ptr when none)
// ---------------------------------------------------------------------------
module rr_arbiter
    import fixpoint_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  req_id_t         ptr,
    output logic [NREQ-1:0] grant,
    output req_id_t         grant_id
);

    int   w_best_dist;
    logic w_found;

    // Pick the asserted request with the smallest rotational distance from ptr.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        w_best_dist = NREQ;
        w_found     = 1'b0;
        grant_id    = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (en && req[i] &&
                (((i >= int'(ptr)) ? i - int'(ptr) : i + NREQ - int'(ptr)) < w_best_dist)) begin
                w_best_dist = (i >= int'(ptr)) ? i - int'(ptr) : i + NREQ - int'(ptr);
                w_found     = 1'b1;
                grant_id    = req_id_t'(i);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = w_found && onehot_bit(grant_id, i);
        end
    end

endmodule

// File: rtl/fixpoint_adder_arbiter.sv
// ---------------------------------------------------------------------------
// fixpoint_adder_arbiter
// Shares one registered fixpoint_adder among NREQ requesters. Round-robin
// arbitration picks at most one request per clock, the operands are
// registered toward the adder, and the requester tag rides a pipeline that
// matches the adder latency so each sum/overflow returns to its owner.
// Ports:
//   CLK, RST            clock (rising) / synchronous active-low reset
//   hold                1 = stop granting; in-flight ops still drain
//   req_valid/req_ready per-requester handshake (ready is one-hot or 0)
//   req_a/req_b         packed operands, requester i at [i*W +: W]
//   add_in1/add_in2     registered operands to the adder
//   add_out/add_ovf     adder result and overflow
//   rsp_valid           one-hot, one-cycle response strobe
//   rsp_data/rsp_ovf    registered result, held between responses
//   ovf_sticky/clr_ovf  per-requester sticky overflow and its clear
//   busy                an op sits in the issue register or tag pipeline
// ---------------------------------------------------------------------------
module fixpoint_adder_arbiter
    import fixpoint_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WI      = WI_DEF,
    parameter int WF      = WF_DEF,
    parameter int WIO     = WIO_DEF,
    parameter int WFO     = WFO_DEF,
    parameter int ADD_LAT = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     hold,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*(WI+WF)-1:0]  req_a,
    input  logic [NREQ*(WI+WF)-1:0]  req_b,
    output logic [WI+WF-1:0]         add_in1,
    output logic [WI+WF-1:0]         add_in2,
    input  logic [WIO+WFO-1:0]       add_out,
    input  logic                     add_ovf,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [WIO+WFO-1:0]       rsp_data,
    output logic                     rsp_ovf,
    output logic [NREQ-1:0]          ovf_sticky,
    input  logic [NREQ-1:0]          clr_ovf,
    output logic                     busy
);

    localparam int OP_W  = WI + WF;
    localparam int RES_W = WIO + WFO;

    logic [NREQ-1:0]  w_grant;
    req_id_t          w_grant_id;
    logic             w_arb_en;
    logic             w_accept;
    logic [OP_W-1:0]  w_sel_a;
    logic [OP_W-1:0]  w_sel_b;
    tag_t             w_last_tag;
    logic [NREQ-1:0]  w_rsp_next;
    logic             w_busy;

    req_id_t          r_ptr;
    logic [OP_W-1:0]  r_add_in1;
    logic [OP_W-1:0]  r_add_in2;
    tag_t             r_issue_tag;
    tag_t             r_tag_pipe [ADD_LAT];
    logic [NREQ-1:0]  r_rsp_valid;
    logic [RES_W-1:0] r_rsp_data;
    logic             r_rsp_ovf;
    logic [NREQ-1:0]  r_ovf_sticky;

    // Gating with RST keeps req_ready low for the whole reset.
    assign w_arb_en = RST & ~hold;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req      (req_valid),
        .en       (w_arb_en),
        .ptr      (r_ptr),
        .grant    (w_grant),
        .grant_id (w_grant_id)
    );

    assign w_accept  = |w_grant;
    assign req_ready = w_grant;

    // Grant is one-hot, so an AND-OR select is enough.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = req_a[i*OP_W +: OP_W];
                w_sel_b = req_b[i*OP_W +: OP_W];
            end
        end
    end

    // The issue tag pairs with add_in1/add_in2; the ADD_LAT pipeline stages
    // behind it line up with the adder, so the last stage names the owner of
    // the add_out value currently presented.
    assign w_last_tag = r_tag_pipe[ADD_LAT-1];

    always_comb begin
        w_rsp_next = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rsp_next[i] = w_last_tag.valid && onehot_bit(w_last_tag.id, i);
        end
    end

    always_comb begin
        w_busy = r_issue_tag.valid;
        for (int s = 0; s < ADD_LAT; s++) begin
            w_busy = w_busy | r_tag_pipe[s].valid;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, which is what makes the tag shift line up.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_ptr        <= '0;
            r_add_in1    <= '0;
            r_add_in2    <= '0;
            r_issue_tag  <= '0;
            // NOTE: the tag pipeline is reset stage by stage because its valid
            // bits decide whether a response fires; stale valids would produce
            // phantom responses after a mid-flight reset.
            for (int s = 0; s < ADD_LAT; s++) begin
                r_tag_pipe[s] <= '0;
            end
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_rsp_ovf    <= 1'b0;
            r_ovf_sticky <= '0;
        end else begin
            if (w_accept) begin
                r_add_in1 <= w_sel_a;
                r_add_in2 <= w_sel_b;
                r_ptr     <= wrap_inc(w_grant_id, NREQ);
            end
            r_issue_tag   <= '{valid: w_accept, id: w_grant_id};
            r_tag_pipe[0] <= r_issue_tag;
            for (int s = 1; s < ADD_LAT; s++) begin
                r_tag_pipe[s] <= r_tag_pipe[s-1];
            end

            r_rsp_valid <= w_rsp_next;
            if (|w_rsp_next) begin
                r_rsp_data <= add_out;
                r_rsp_ovf  <= add_ovf;
            end

            // A new overflow wins over a same-cycle clear.
            r_ovf_sticky <= (r_ovf_sticky & ~clr_ovf) | (w_rsp_next & {NREQ{add_ovf}});
        end
    end

    assign add_in1    = r_add_in1;
    assign add_in2    = r_add_in2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_ovf    = r_rsp_ovf;
    assign ovf_sticky = r_ovf_sticky;
    assign busy       = w_busy;

endmodule

// File: tb/tb_fixpoint_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fixpoint_adder_arbiter
// Drives the arbiter with directed and random traffic. A behavioural model
// (rotating-priority pick, queue of pending sums with due cycles, sticky
// flags) predicts every output. A saturating adder with one cycle of latency
// stands in for fixpoint_adder.
// ---------------------------------------------------------------------------
module tb_fixpoint_adder_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int ADD_LAT = 1;

    typedef struct {
        int          id;
        logic [W-1:0] sum;
        logic        ovf;
        int          due;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RST;
    logic              hold;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      add_in1;
    logic [W-1:0]      add_in2;
    logic [W-1:0]      add_out;
    logic              add_ovf;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              rsp_ovf;
    logic [NREQ-1:0]   ovf_sticky;
    logic [NREQ-1:0]   clr_ovf;
    logic              busy;

    logic [W-1:0] op_a [NREQ];
    logic [W-1:0] op_b [NREQ];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int           cyc = 0;
    int           m_ptr = 0;
    logic [NREQ-1:0] m_sticky = '0;
    logic [W-1:0] m_in1 = '0;
    logic [W-1:0] m_in2 = '0;
    logic [W-1:0] m_data = '0;
    logic         m_ovf = 1'b0;
    exp_t         q [$];

    always #5 CLK = ~CLK;

    fixpoint_adder_arbiter #(
        .NREQ(NREQ), .WI(8), .WF(8), .WIO(8), .WFO(8), .ADD_LAT(ADD_LAT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .hold       (hold),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_in1    (add_in1),
        .add_in2    (add_in2),
        .add_out    (add_out),
        .add_ovf    (add_ovf),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_ovf    (rsp_ovf),
        .ovf_sticky (ovf_sticky),
        .clr_ovf    (clr_ovf),
        .busy       (busy)
    );

    // Q8.8 + Q8.8 -> Q8.8 with saturation; bit W is the overflow flag.
    function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767)  return {1'b1, 16'h7FFF};
        if (s < -32768) return {1'b1, 16'h8000};
        return {1'b0, s[15:0]};
    endfunction

    // Stand-in for the shared adder: one registered stage.
    always @(posedge CLK) begin
        if (!RST) begin
            add_out <= '0;
            add_ovf <= 1'b0;
        end else begin
            {add_ovf, add_out} <= sat_add(add_in1, add_in2);
        end
    end

    // One clock of traffic: drive, predict, check req_ready before the edge,
    // then check every registered output 1 time unit after the edge.
    task automatic step(output int gid, output logic [NREQ-1:0] obs);
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rv;
        logic [W:0]      r;
        logic [NREQ*W-1:0] pa;
        logic [NREQ*W-1:0] pb;
        exp_t            e;
        pa = '0;
        pb = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            pa = (pa << W) | (NREQ*W)'(op_a[i]);
            pb = (pb << W) | (NREQ*W)'(op_b[i]);
        end
        req_a = pa;
        req_b = pb;
        #1;
        gid = -1;
        if (RST && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                if (gid < 0 && ((req_valid >> ((m_ptr + k) % NREQ)) & 1) != 0)
                    gid = (m_ptr + k) % NREQ;
            end
        end
        exp_ready = (gid >= 0) ? NREQ'(1) << gid : '0;
        obs = req_ready;
        n_tests++;
        if (req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
        end
        if (gid >= 0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i == gid) begin
                    r = sat_add(op_a[i], op_b[i]);
                    e.id = i; e.sum = r[W-1:0]; e.ovf = r[W]; e.due = cyc + ADD_LAT + 2;
                    q.push_back(e);
                    m_in1 = op_a[i];
                    m_in2 = op_b[i];
                end
            end
            m_ptr = (gid + 1) % NREQ;
        end
        @(posedge CLK);
        cyc++;
        exp_rv = '0;
        if (!RST) begin
            q.delete();
            m_ptr = 0; m_sticky = '0; m_in1 = '0; m_in2 = '0; m_data = '0; m_ovf = 1'b0;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                exp_rv = NREQ'(1) << e.id;
                m_data = e.sum;
                m_ovf  = e.ovf;
            end
            m_sticky = (m_sticky & ~clr_ovf) | (m_ovf && exp_rv != 0 ? exp_rv : '0);
        end
        #1;
        n_tests++;
        if (rsp_valid !== exp_rv) begin
            n_fail++;
            $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv);
        end
        n_tests++;
        if (rsp_data !== m_data || rsp_ovf !== m_ovf) begin
            n_fail++;
            $display("FAIL rsp_data cyc=%0d got=%h/%b exp=%h/%b", cyc, rsp_data, rsp_ovf, m_data, m_ovf);
        end
        n_tests++;
        if (ovf_sticky !== m_sticky) begin
            n_fail++;
            $display("FAIL ovf_sticky cyc=%0d got=%b exp=%b", cyc, ovf_sticky, m_sticky);
        end
        n_tests++;
        if (add_in1 !== m_in1 || add_in2 !== m_in2) begin
            n_fail++;
            $display("FAIL add_in cyc=%0d got=%h,%h exp=%h,%h", cyc, add_in1, add_in2, m_in1, m_in2);
        end
        n_tests++;
        if (busy !== (q.size() != 0)) begin
            n_fail++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, q.size() != 0);
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        int g;
        logic [NREQ-1:0] o;
        RST = 1'b0; req_valid = '0; hold = 1'b0; clr_ovf = '0;
        step(g, o);
        step(g, o);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        int g;
        logic [NREQ-1:0] o;
        RST = 1'b0; hold = 1'b0; clr_ovf = '0;
        req_valid = '1;
        step(g, o);
        n_tests++;
        if (o !== '0 || rsp_valid !== '0 || ovf_sticky !== '0 || busy !== 1'b0 || add_in1 !== '0) begin
            n_fail++;
            $display("FAIL reset_state ready=%b rv=%b sticky=%b busy=%b in1=%h exp all zero",
                     o, rsp_valid, ovf_sticky, busy, add_in1);
        end
        req_valid = '0;
        step(g, o);
        RST = 1'b1;
    endtask

    task automatic test_single();
        int g;
        logic [NREQ-1:0] o;
        req_valid = 4'b0001; op_a[0] = 16'h0180; op_b[0] = 16'h0240;
        step(g, o);
        req_valid = '0;
        step(g, o);
        step(g, o);
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 16'h03C0 || rsp_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL single got=%b/%h/%b exp=0001/03c0/0", rsp_valid, rsp_data, rsp_ovf);
        end
        step(g, o);
    endtask

    task automatic test_round_robin();
        int g;
        logic [NREQ-1:0] o;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = W'($urandom); op_b[i] = W'($urandom);
        end
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            step(g, o);
            n_tests++;
            if (o !== NREQ'(1) << (c % NREQ)) begin
                n_fail++;
                $display("FAIL rr_order c=%0d got=%b exp=%b", c, o, NREQ'(1) << (c % NREQ));
            end
            if (g >= 0) begin
                op_a[g] = W'($urandom); op_b[g] = W'($urandom);
            end
        end
        req_valid = '0;
        for (int c = 0; c < 3; c++) step(g, o);
    endtask

    task automatic test_overflow_sticky();
        int g;
        logic [NREQ-1:0] o;
        req_valid = 4'b0100; op_a[2] = 16'h6400; op_b[2] = 16'h6400;
        step(g, o);
        req_valid = '0;
        step(g, o);
        step(g, o);
        n_tests++;
        if (rsp_ovf !== 1'b1 || ovf_sticky[2] !== 1'b1 || rsp_data !== 16'h7FFF) begin
            n_fail++;
            $display("FAIL ovf_first got ovf=%b sticky=%b data=%h exp 1/1/7fff", rsp_ovf, ovf_sticky[2], rsp_data);
        end
        req_valid = 4'b0100;
        step(g, o);
        req_valid = '0;
        step(g, o);
        clr_ovf = 4'b0100;
        step(g, o);
        n_tests++;
        if (ovf_sticky[2] !== 1'b1 || rsp_valid !== 4'b0100) begin
            n_fail++;
            $display("FAIL ovf_set_wins got sticky=%b rv=%b exp 1/0100", ovf_sticky[2], rsp_valid);
        end
        clr_ovf = '0;
        step(g, o);
        clr_ovf = 4'b0100;
        step(g, o);
        clr_ovf = '0;
        n_tests++;
        if (ovf_sticky[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got=%b exp=0", ovf_sticky[2]);
        end
    endtask

    task automatic test_hold_drain();
        int g;
        int n_rsp;
        logic [NREQ-1:0] o;
        do_reset();
        n_rsp = 0;
        req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            step(g, o);
            n_rsp += $countones(rsp_valid);
            if (g >= 0) begin
                op_a[g] = W'($urandom); op_b[g] = W'($urandom);
            end
        end
        hold = 1'b1;
        step(g, o);
        n_rsp += $countones(rsp_valid);
        n_tests++;
        if (o !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_edge1 ready=%b busy=%b exp 0000/1", o, busy);
        end
        step(g, o);
        n_rsp += $countones(rsp_valid);
        n_tests++;
        if (o !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_edge2 ready=%b busy=%b exp 0000/0", o, busy);
        end
        for (int c = 0; c < 2; c++) begin
            step(g, o);
            n_rsp += $countones(rsp_valid);
        end
        n_tests++;
        if (n_rsp !== 3) begin
            n_fail++;
            $display("FAIL hold_drain_count got=%0d exp=3", n_rsp);
        end
        hold = 1'b0;
        step(g, o);
        n_tests++;
        if (o !== 4'b1000) begin
            n_fail++;
            $display("FAIL hold_resume got=%b exp=1000", o);
        end
        req_valid = '0;
        for (int c = 0; c < 3; c++) step(g, o);
    endtask

    task automatic test_reset_midflight();
        int g;
        int n_rsp;
        logic [NREQ-1:0] o;
        req_valid = 4'b0010; op_a[1] = W'($urandom); op_b[1] = W'($urandom);
        step(g, o);
        req_valid = '0;
        RST = 1'b0;
        step(g, o);
        n_tests++;
        if (rsp_valid !== '0 || rsp_data !== '0 || rsp_ovf !== 1'b0 || add_in1 !== '0 ||
            add_in2 !== '0 || ovf_sticky !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_reset rv=%b data=%h in=%h,%h sticky=%b busy=%b exp all zero",
                     rsp_valid, rsp_data, add_in1, add_in2, ovf_sticky, busy);
        end
        RST = 1'b1;
        n_rsp = 0;
        for (int c = 0; c < 4; c++) begin
            step(g, o);
            n_rsp += $countones(rsp_valid);
        end
        n_tests++;
        if (n_rsp !== 0) begin
            n_fail++;
            $display("FAIL midflight_phantom got=%0d responses exp=0", n_rsp);
        end
        req_valid = 4'b1000; op_a[3] = W'($urandom); op_b[3] = W'($urandom);
        step(g, o);
        n_tests++;
        if (o !== 4'b1000) begin
            n_fail++;
            $display("FAIL post_reset_grant got=%b exp=1000", o);
        end
        req_valid = '0;
        for (int c = 0; c < 3; c++) step(g, o);
    endtask

    task automatic test_sparse();
        int g;
        int n_rsp;
        int who;
        logic [NREQ-1:0] o;
        n_rsp = 0;
        for (int c = 0; c < 18; c++) begin
            if (c % 3 == 0) begin
                who = ((c / 3) % 2 == 1) ? 3 : 1;
                req_valid[who] = 1'b1;
                op_a[who] = W'($urandom); op_b[who] = W'($urandom);
            end
            step(g, o);
            n_rsp += $countones(rsp_valid);
            if (g >= 0) req_valid[g] = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            step(g, o);
            n_rsp += $countones(rsp_valid);
        end
        n_tests++;
        if (n_rsp !== 6) begin
            n_fail++;
            $display("FAIL sparse_count got=%0d exp=6", n_rsp);
        end
    endtask

    task automatic test_random();
        int g;
        logic [NREQ-1:0] o;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    op_a[i] = W'($urandom); op_b[i] = W'($urandom);
                end
                clr_ovf[i] = ($urandom_range(0, 7) == 0);
            end
            hold = ($urandom_range(0, 7) == 0);
            step(g, o);
            if (g >= 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    req_valid[g] = 1'b0;
                end else begin
                    op_a[g] = W'($urandom); op_b[g] = W'($urandom);
                end
            end
        end
        req_valid = '0; hold = 1'b0; clr_ovf = '0;
        for (int c = 0; c < 4; c++) step(g, o);
    endtask

    initial begin
        RST = 1'b0; hold = 1'b0; clr_ovf = '0; req_valid = '0;
        req_a = '0; req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0; op_b[i] = '0;
        end
        @(negedge CLK);
        test_reset();
        test_single();
        test_round_robin();
        test_overflow_sticky();
        test_hold_drain();
        test_reset_midflight();
        test_sparse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fixpoint_adder_arbiter.md
Name: fixpoint_adder_arbiter

Overview:
Shares one registered fixpoint_adder instance among NREQ requesters using work-conserving round-robin arbitration with valid/ready handshakes.
- Issues at most one add per clock.
- Tracks the requester tag through the adder latency and returns each sum and OVF to the correct requester.
- Keeps a sticky per-requester overflow flag.
- Sits between the IIR filter section datapaths and the single shared adder.

Parameters:
NREQ, 4, number of requesters (2..8)
WI, 8, integer bits of both operands (sign included)
WF, 8, fraction bits of both operands
WIO, 8, integer bits of adder output
WFO, 8, fraction bits of adder output
ADD_LAT, 1, adder input-to-output latency in clock edges (at least 1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-low
hold  in  1  1 = stop accepting new requests; in-flight ops still drain
req_valid  in  NREQ  per-requester request
req_ready  out  NREQ  per-requester grant; at most one bit high
req_a  in  NREQ*(WI+WF)  operand A, requester i at slice [i*(WI+WF) +: WI+WF]
req_b  in  NREQ*(WI+WF)  operand B, same packing
add_in1  out  WI+WF  registered operand to adder in1
add_in2  out  WI+WF  registered operand to adder in2
add_out  in  WIO+WFO  adder result
add_ovf  in  1  adder overflow, aligned with add_out
rsp_valid  out  NREQ  one-hot response strobe, one cycle
rsp_data  out  WIO+WFO  registered sum
rsp_ovf  out  1  overflow for this response
ovf_sticky  out  NREQ  per-requester sticky overflow
clr_ovf  in  NREQ  per-requester clear of ovf_sticky
busy  out  1  any op in issue register or tag pipeline

Behaviour:
- Reset, RST low at a rising edge:
  - Clears ptr to 0, tag pipeline valids, add_in1/add_in2, rsp_valid, rsp_data, rsp_ovf and ovf_sticky.
  - req_ready is all 0 while RST is low.
  - Reset mid-operation drops every in-flight op; no response is ever produced for it.
  - The adder receives the same RST.
- Arbitration is combinational within the cycle:
  - If hold=0, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NREQ.
  - req_ready = one-hot(grant). With no valid requests or hold=1, req_ready=0.
  - A requester may hold req_valid until it sees ready; its operands must stay stable while it waits.
- Handshake: req_valid[i] & req_ready[i] at edge E0 means accepted.
  - At E0: add_in1 <= req_a slice i, add_in2 <= req_b slice i, tag[0] <= {1, i}, ptr <= (i+1) mod NREQ.
  - With no acceptance, ptr is held, tag[0].valid <= 0, and add_in1/add_in2 hold their values.
- Tag pipeline: ADD_LAT stages shift every edge with no stall, so it matches the adder latency exactly.
- Response, at edge E0+ADD_LAT+1:
  - rsp_data <= add_out, rsp_ovf <= add_ovf, rsp_valid <= one-hot(tag[ADD_LAT-1].id) if that tag is valid, else 0.
  - Latency from acceptance edge to rsp_valid visible: ADD_LAT+1 edges (2 by default).
  - Throughput: one add per cycle. Back-to-back grants give back-to-back responses in grant order.
- rsp_data and rsp_ovf hold their value when rsp_valid=0.
- Sticky overflow: ovf_sticky[i] <= (ovf_sticky[i] & ~clr_ovf[i]) | (rsp_valid_next[i] & add_ovf). Set wins over a simultaneous clear.
- hold rising: no new grants from that cycle on. busy falls ADD_LAT+1 edges after the last acceptance.
- Arithmetic: the block never modifies data. Format alignment, rounding and saturation belong to fixpoint_adder.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once per NREQ cycles.

Decomposition:
- Shared package fixpoint_pkg:
  - operand width constant W_OP = WI+WF and result width W_RES = WIO+WFO.
  - tag typedef {valid, id[$clog2(NREQ)-1:0]}.
  - onehot/priority helper functions.
- One sub-module: rr_arbiter (NREQ parameter; inputs req, en, ptr; outputs grant one-hot and grant_id).
- The tag pipeline and response register stay in the top.

Test Plan:
- Single request: req0 with A=0x0180 (1.5), B=0x0240 (2.25), hold=0. Accept at edge 0 -> rsp_valid=4'b0001 after edge 2, rsp_data=0x03C0 (3.75), rsp_ovf=0.
- All four valid for 8 cycles, ptr=0 -> grant order 0,1,2,3,0,1,2,3. Responses one per cycle in the same order, each sum matching its requester.
- Overflow and sticky: req2 with A=B=0x6400 (100.0) -> rsp_ovf=1 and ovf_sticky[2]=1. When clr_ovf[2] coincides with a second overflowing response for req2, ovf_sticky[2] stays 1; a later clr_ovf[2] alone clears it.
- Hold drain: 3 ops accepted, then hold=1 with all still valid -> req_ready=0, 3 responses emitted, busy=0 exactly 2 edges after the last acceptance. hold=0 resumes at the stored ptr.
- Reset mid-flight: accept req1, drive RST=0 on the next edge -> no rsp_valid ever for req1, all outputs 0, ptr=0. After RST=1, req3 alone is granted on the first cycle.
- Sparse traffic: req1 and req3 alternate with gaps -> ptr advances only on grants, and no phantom rsp_valid appears in idle cycles.
